// File: rtl/fft_pkg.sv
// fft_pkg
//  Shared constants, types and helpers for the fftmain output serializer.
//  OWIDTH : bits per real/imag component produced by fftmain
//  LGN    : log2 of the FFT size
//  cplx_t : {re, im}, both signed OWIDTH bits (re in the upper half)
//  pair_t : {first, l, r}; one FIFO entry holding an even/odd bin pair
//  cplx_mag() : |re| + |im| as an unsigned OWIDTH+1 bit value, saturating

package fft_pkg;

    localparam int OWIDTH = 19;
    localparam int LGN    = 12;

    typedef struct packed {
        logic signed [OWIDTH-1:0] re;
        logic signed [OWIDTH-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic  first;   // pair carries bins 0/1 of a frame
        cplx_t l;       // even bin 2k
        cplx_t r;       // odd bin 2k+1
    } pair_t;

    // Each component is widened by one bit before negation so the most
    // negative input maps to +2^(OWIDTH-1) instead of wrapping.
    function automatic logic [OWIDTH:0] cplx_mag(input cplx_t c);
        logic [OWIDTH:0]   re_x;
        logic [OWIDTH:0]   im_x;
        logic [OWIDTH:0]   re_a;
        logic [OWIDTH:0]   im_a;
        logic [OWIDTH+1:0] sum;
        re_x = {c.re[OWIDTH-1], c.re};
        im_x = {c.im[OWIDTH-1], c.im};
        re_a = re_x[OWIDTH] ? (~re_x + (OWIDTH+1)'(1)) : re_x;
        im_a = im_x[OWIDTH] ? (~im_x + (OWIDTH+1)'(1)) : im_x;
        sum  = {1'b0, re_a} + {1'b0, im_a};
        cplx_mag = sum[OWIDTH+1] ? {(OWIDTH+1){1'b1}} : sum[OWIDTH:0];
    endfunction

endpackage

// File: rtl/fft_pair_fifo.sv
// fft_pair_fifo
//  Small register-based synchronous FIFO of pair_t entries with a
//  combinational head, so a pair pushed on one edge is visible on the
//  next cycle. Push when full and pop when empty are ignored.
//  i_clk, i_reset_n : clock, async active-low reset (clears pointers/count)
//  i_push, i_data   : write request and entry
//  i_pop            : remove the head entry
//  o_head           : current head entry (undefined while empty)
//  o_count          : occupancy in entries, 0..DEPTH
//  o_empty          : occupancy is zero

module fft_pair_fifo
    import fft_pkg::*;
#(
    parameter int LGDEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  pair_t            i_data,
    input  logic             i_pop,
    output pair_t            o_head,
    output logic [LGDEPTH:0] o_count,
    output logic             o_empty
);

    localparam int DEPTH = 1 << LGDEPTH;
    localparam logic [LGDEPTH:0] DEPTH_CNT = (LGDEPTH+1)'(DEPTH);

    pair_t               slot_q [DEPTH];
    logic [LGDEPTH-1:0]  wr_ptr_reg;
    logic [LGDEPTH-1:0]  rd_ptr_reg;
    logic [LGDEPTH:0]    count_reg;
    logic                do_push;
    logic                do_pop;

    assign o_empty = (count_reg == '0);
    assign do_push = i_push && (count_reg != DEPTH_CNT);
    assign do_pop  = i_pop && !o_empty;
    assign o_count = count_reg;
    assign o_head  = slot_q[rd_ptr_reg];

    // Storage slots carry no reset: the data is only looked at while the
    // occupancy says the slot holds a live entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        pair_t slot_reg;
        always_ff @(posedge i_clk) begin
            if (do_push && (wr_ptr_reg == LGDEPTH'(gi))) begin
                slot_reg <= i_data;
            end
        end
        assign slot_q[gi] = slot_reg;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + LGDEPTH'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + LGDEPTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (LGDEPTH+1)'(1);
                2'b01:   count_reg <= count_reg - (LGDEPTH+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fft_out_serializer.sv
// fft_out_serializer
//  Takes the two-bins-per-clock output of fftmain and re-emits one complex
//  bin per clock on a valid/ready stream, with bin index, frame-last flag
//  and |re|+|im| magnitude. The FFT clock enable is throttled so the pair
//  FIFO can never overflow and no bin is lost under backpressure.
//  i_clk, i_reset_n  : clock, async active-low reset
//  i_en              : run enable; low freezes the FFT core
//  o_fft_ce          : clock enable to fftmain
//  i_left/i_right    : {re,im} of even / odd bin, i_sync marks bins 0/1
//  o_valid/i_ready   : output handshake
//  o_data, o_bin     : current bin {re,im} and its index
//  o_last            : o_bin is N-1
//  o_mag             : |re|+|im|
//  o_sync_err        : sticky, a sync pair arrived mid-frame after lock

module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int FIFO_LGDEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_en,
    output logic                o_fft_ce,
    input  logic [2*OWIDTH-1:0] i_left,
    input  logic [2*OWIDTH-1:0] i_right,
    input  logic                i_sync,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [2*OWIDTH-1:0] o_data,
    output logic [LGN-1:0]      o_bin,
    output logic                o_last,
    output logic [OWIDTH:0]     o_mag,
    output logic                o_sync_err
);

    localparam int DEPTH = 1 << FIFO_LGDEPTH;

    pair_t                   in_pair;
    pair_t                   head;
    logic [FIFO_LGDEPTH:0]   used;
    logic                    empty;
    logic [FIFO_LGDEPTH+1:0] committed;

    logic                    run_reg;
    logic                    ce_d_reg;
    logic                    locked_reg;
    logic                    sync_err_reg;
    logic                    half_reg;
    logic [LGN-2:0]          pair_cnt_reg;
    logic [LGN-1:0]          bin_reg;

    logic                    push;
    logic                    pop;
    logic                    accept;
    logic [LGN-1:0]          cur_bin;
    cplx_t                   cur_data;

    // A pair requested by ce lands one clock later, so the pair still in
    // flight (ce_d) already owns a FIFO slot when deciding the next enable.
    assign committed = {1'b0, used} + (FIFO_LGDEPTH+2)'(ce_d_reg);
    assign o_fft_ce  = run_reg && i_en && (committed < (FIFO_LGDEPTH+2)'(DEPTH));

    // Pairs seen before the first sync belong to an unknown frame position
    // and are discarded.
    assign push = ce_d_reg && (locked_reg || i_sync);

    always_comb begin
        in_pair       = '0;
        in_pair.first = i_sync;
        in_pair.l     = i_left;
        in_pair.r     = i_right;
    end

    fft_pair_fifo #(
        .LGDEPTH (FIFO_LGDEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (push),
        .i_data    (in_pair),
        .i_pop     (pop),
        .o_head    (head),
        .o_count   (used),
        .o_empty   (empty)
    );

    // Output stage: the head pair is presented as two consecutive bins,
    // and only retired once its odd half has been accepted.
    assign o_valid  = !empty;
    assign accept   = o_valid && i_ready;
    assign pop      = accept && half_reg;
    assign cur_data = half_reg ? head.r : head.l;
    assign cur_bin  = (head.first && !half_reg) ? '0 : bin_reg + LGN'(1);

    assign o_data     = o_valid ? cur_data : '0;
    assign o_bin      = o_valid ? cur_bin : '0;
    assign o_last     = o_valid && (cur_bin == {LGN{1'b1}});
    assign o_mag      = o_valid ? cplx_mag(cur_data) : '0;
    assign o_sync_err = sync_err_reg;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run_reg      <= 1'b0;
            ce_d_reg     <= 1'b0;
            locked_reg   <= 1'b0;
            sync_err_reg <= 1'b0;
            half_reg     <= 1'b0;
            pair_cnt_reg <= '0;
            bin_reg      <= '0;
        end else begin
            run_reg  <= 1'b1;
            ce_d_reg <= o_fft_ce;
            if (push) begin
                locked_reg <= 1'b1;
                if (i_sync) begin
                    // A sync is only expected where the pair count wrapped.
                    if (locked_reg && (pair_cnt_reg != '0)) begin
                        sync_err_reg <= 1'b1;
                    end
                    pair_cnt_reg <= (LGN-1)'(1);
                end else begin
                    pair_cnt_reg <= pair_cnt_reg + (LGN-1)'(1);
                end
            end
            if (accept) begin
                half_reg <= !half_reg;
                bin_reg  <= cur_bin;
            end
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
`timescale 1ns/1ps
// Bench for fft_out_serializer: emulates the fftmain source (a new pair
// appears one clock after each sampled o_fft_ce), keeps a frame-level
// reference model, and checks every accepted bin from a separate monitor.

module tb_fft_out_serializer;
    import fft_pkg::*;

    localparam int W2      = 2 * OWIDTH;
    localparam int N       = 1 << LGN;
    localparam int NP      = N / 2;
    localparam int DEPTH   = 4;
    localparam int MAG_MAX = (1 << (OWIDTH + 1)) - 1;

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b0;
    logic              i_en = 1'b0;
    logic              o_fft_ce;
    logic [W2-1:0]     i_left = '0;
    logic [W2-1:0]     i_right = '0;
    logic              i_sync = 1'b0;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [W2-1:0]     o_data;
    logic [LGN-1:0]    o_bin;
    logic              o_last;
    logic [OWIDTH:0]   o_mag;
    logic              o_sync_err;

    fft_out_serializer #(.FIFO_LGDEPTH(2)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_en       (i_en),
        .o_fft_ce   (o_fft_ce),
        .i_left     (i_left),
        .i_right    (i_right),
        .i_sync     (i_sync),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_bin      (o_bin),
        .o_last     (o_last),
        .o_mag      (o_mag),
        .o_sync_err (o_sync_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit            sync;
        logic [W2-1:0] l;
        logic [W2-1:0] r;
    } src_t;

    typedef struct {
        logic [W2-1:0] data;
        int            bin;
        bit            last;
        int            mag;
    } exp_t;

    src_t src_q[$];
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int n_rx = 0;
    int en_pct = 100;
    int rdy_pct = 100;
    bit gap_chk = 1'b0;
    bit verbose = 1'b0;

    // reference model state: frame lock, pair position inside the frame
    bit m_locked = 1'b0;
    bit m_err = 1'b0;
    int m_pidx = 0;

    function automatic logic [W2-1:0] rnd();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        return x[W2-1:0];
    endfunction

    function automatic src_t cx(bit s, int lre, int lim, int rre, int rim);
        src_t p;
        p.sync = s;
        p.l = {OWIDTH'(lre), OWIDTH'(lim)};
        p.r = {OWIDTH'(rre), OWIDTH'(rim)};
        return p;
    endfunction

    function automatic int ref_mag(logic [W2-1:0] d);
        int re;
        int im;
        int s;
        re = int'($signed(d[W2-1:OWIDTH]));
        im = int'($signed(d[OWIDTH-1:0]));
        if (re < 0) re = -re;
        if (im < 0) im = -im;
        s = re + im;
        if (s > MAG_MAX) s = MAG_MAX;
        return s;
    endfunction

    // Frame semantics: nothing before the first sync; a sync starts a frame
    // at pair 0 (error if the current frame was not complete); pair k of a
    // frame yields bins 2k and 2k+1.
    function automatic void model_pair(src_t p);
        exp_t e;
        if (!m_locked && !p.sync) return;
        if (p.sync) begin
            if (m_locked && m_pidx != 0) m_err = 1'b1;
            m_locked = 1'b1;
            m_pidx = 0;
        end
        for (int k = 0; k < 2; k++) begin
            e.data = (k == 0) ? p.l : p.r;
            e.bin  = 2 * m_pidx + k;
            e.last = (e.bin == N - 1);
            e.mag  = ref_mag(e.data);
            exp_q.push_back(e);
        end
        m_pidx = (m_pidx + 1) % NP;
    endfunction

    task automatic chk(string name, longint act, longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic add_rand(int n, bit first_sync);
        src_t p;
        for (int i = 0; i < n; i++) begin
            p.sync = first_sync && (i == 0);
            p.l = rnd();
            p.r = rnd();
            src_q.push_back(p);
        end
    endtask

    // One clock of the emulated fftmain source plus random handshake drive.
    task automatic step();
        bit   ce_s;
        bit   en_s;
        src_t p;
        @(negedge i_clk);
        ce_s = o_fft_ce;
        en_s = i_en;
        if (!en_s) chk("ce_without_en", o_fft_ce, 0);
        @(posedge i_clk);
        #1;
        if (ce_s) begin
            total++;
            if (src_q.size() == 0) begin
                bad++;
                $display("FAIL ce_no_data: o_fft_ce=1 but no pair was pending");
            end else begin
                p = src_q.pop_front();
                i_sync  = p.sync;
                i_left  = p.l;
                i_right = p.r;
                model_pair(p);
            end
        end
        i_en    = (src_q.size() != 0) && ($urandom_range(99) < en_pct);
        i_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic drain(string name, int budget);
        int c;
        c = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
            step();
            c++;
        end
        total++;
        if (src_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d pairs and %0d bins still pending after %0d cycles",
                     name, src_q.size(), exp_q.size(), budget);
        end
    endtask

    task automatic do_reset(int cycles);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b0;
        i_en = 1'b1;
        src_q.delete();
        exp_q.delete();
        m_locked = 1'b0;
        m_err = 1'b0;
        m_pidx = 0;
        for (int i = 0; i < cycles; i++) begin
            i_left  = rnd();
            i_right = rnd();
            i_sync  = 1'($urandom_range(1));
            i_ready = 1'($urandom_range(1));
            @(negedge i_clk);
            chk("rst_fft_ce", o_fft_ce, 0);
            chk("rst_valid", o_valid, 0);
            chk("rst_sync_err", o_sync_err, 0);
            chk("rst_last", o_last, 0);
            chk("rst_bin", o_bin, 0);
            chk("rst_mag", o_mag, 0);
            chk("rst_data_zero", (o_data == '0), 1);
            @(posedge i_clk);
            #1;
        end
        i_reset_n = 1'b1;
        i_en = 1'b0;
        i_sync = 1'b0;
    endtask

    // Monitor: occupancy bound, hold-while-stalled, gap-free stream, and
    // scoreboard comparison of every accepted bin.
    initial begin
        bit              held_v;
        logic [W2-1:0]   h_data;
        logic [LGN-1:0]  h_bin;
        logic [OWIDTH:0] h_mag;
        logic            h_last;
        int              outst;
        exp_t            e;
        held_v = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                held_v = 1'b0;
                continue;
            end
            outst = (exp_q.size() + 1) / 2;
            total++;
            if (outst + int'(o_fft_ce) > DEPTH) begin
                bad++;
                $display("FAIL occupancy: pending pairs=%0d with o_fft_ce=%0b exceeds depth %0d",
                         outst, o_fft_ce, DEPTH);
            end
            if (held_v) begin
                total++;
                if (!o_valid || o_data !== h_data || o_bin !== h_bin ||
                    o_mag !== h_mag || o_last !== h_last) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%0b bin=%0d data=%h, required bin=%0d data=%h held",
                             o_valid, o_bin, o_data, h_bin, h_data);
                end
            end
            if (gap_chk && n_rx > 0 && n_rx < N) begin
                total++;
                if (!o_valid) begin
                    bad++;
                    $display("FAIL gap: o_valid=0 after %0d bins, required continuous stream", n_rx);
                end
            end
            held_v = 1'b0;
            if (o_valid) begin
                if (!i_ready) begin
                    held_v = 1'b1;
                    h_data = o_data;
                    h_bin  = o_bin;
                    h_mag  = o_mag;
                    h_last = o_last;
                end else begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_bin: got bin=%0d data=%h, required no output",
                                 o_bin, o_data);
                    end else begin
                        e = exp_q.pop_front();
                        n_rx++;
                        if (o_data !== e.data || int'(o_bin) != e.bin ||
                            o_last !== e.last || int'(o_mag) != e.mag) begin
                            bad++;
                            $display("FAIL bin_check: got bin=%0d data=%h mag=%0d last=%0b, required bin=%0d data=%h mag=%0d last=%0b",
                                     o_bin, o_data, o_mag, o_last, e.bin, e.data, e.mag, e.last);
                        end else if (verbose) begin
                            $display("bin %0d data=%h mag=%0d last=%0b ok", o_bin, o_data, o_mag, o_last);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset with random inputs and i_en=1
        do_reset(4);

        // T2: impulse frame, full throughput, no gaps
        $display("T2 impulse frame");
        en_pct = 100; rdy_pct = 100; n_rx = 0; gap_chk = 1'b1;
        for (int i = 0; i < NP; i++) src_q.push_back(cx(i == 0, 2047 * 64, 0, 2047 * 64, 0));
        drain("t2", 20000);
        chk("t2_bin_count", n_rx, N);
        gap_chk = 1'b0;
        @(negedge i_clk);
        chk("t2_sync_err", o_sync_err, m_err);

        // T3: random data, random enable and 30% ready
        $display("T3 backpressure frame");
        en_pct = 80; rdy_pct = 30; n_rx = 0;
        add_rand(NP, 1'b1);
        drain("t3", 40000);
        chk("t3_bin_count", n_rx, N);
        @(negedge i_clk);
        chk("t3_sync_err", o_sync_err, m_err);

        // T4: pairs before the first sync are dropped
        $display("T4 pre-lock");
        do_reset(2);
        en_pct = 100; rdy_pct = 100; n_rx = 0;
        add_rand(5, 1'b0);
        add_rand(NP, 1'b1);
        drain("t4", 20000);
        chk("t4_bin_count", n_rx, N);
        @(negedge i_clk);
        chk("t4_sync_err", o_sync_err, m_err);

        // T5: sync at pair 100 of a frame
        $display("T5 early re-sync");
        verbose = 1'b1; en_pct = 90; rdy_pct = 50;
        add_rand(100, 1'b1);
        drain("t5a", 4000);
        @(negedge i_clk);
        chk("t5_err_before", o_sync_err, m_err);
        add_rand(40, 1'b1);
        drain("t5b", 4000);
        @(negedge i_clk);
        chk("t5_err_after", o_sync_err, m_err);
        add_rand(10, 1'b0);
        drain("t5c", 4000);
        @(negedge i_clk);
        chk("t5_err_sticky", o_sync_err, m_err);

        // T6: magnitude corners, then reset mid-frame and relock
        $display("T6 magnitude and mid-frame reset");
        en_pct = 100; rdy_pct = 70;
        src_q.push_back(cx(1'b1, -262144, 0, -5, 7));
        src_q.push_back(cx(1'b0, -262144, -262144, 262143, -1));
        src_q.push_back(cx(1'b0, 262143, 262143, 0, 0));
        add_rand(300, 1'b0);
        for (int i = 0; i < 200; i++) step();
        do_reset(3);
        add_rand(3, 1'b0);
        add_rand(30, 1'b1);
        drain("t6", 4000);
        @(negedge i_clk);
        chk("t6_err_cleared", o_sync_err, m_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
